// File: rtl/alu_seq_pkg.sv
// ============================================================================
// Module  : alu_seq_pkg
// Brief   : Opcodes, FSM state encoding and op-class helper for alu_seq.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_seq_pkg;

   localparam logic [3:0] OP_AND  = 4'd0;
   localparam logic [3:0] OP_OR   = 4'd1;
   localparam logic [3:0] OP_XOR  = 4'd2;
   localparam logic [3:0] OP_ADD  = 4'd3;
   localparam logic [3:0] OP_SUB  = 4'd4;
   localparam logic [3:0] OP_SLL  = 4'd5;
   localparam logic [3:0] OP_SRL  = 4'd6;
   localparam logic [3:0] OP_SRA  = 4'd7;
   localparam logic [3:0] OP_SLT  = 4'd8;
   localparam logic [3:0] OP_SLTU = 4'd9;
   localparam logic [3:0] OP_MUL  = 4'd10;
   localparam logic [3:0] OP_DIVU = 4'd11;
   localparam logic [3:0] OP_REMU = 4'd12;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Ops that go through the shared multi-cycle multiplier/divider.
   function automatic logic is_iterative(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu_seq_muldiv.sv
// ============================================================================
// Module  : alu_seq_muldiv
// Brief   : Shared WIDTH-step shift-add multiplier / restoring divider.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq_muldiv
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int OP_W  = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [OP_W-1:0]  op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o
);

   localparam int c_CNT_W = $clog2(WIDTH) + 1;

   // r_acc: product accumulator (MUL) or partial remainder (DIVU/REMU).
   // r_opnd: shifted multiplicand (MUL) or dividend/quotient shift register.
   // r_b: shifted multiplier (MUL) or divisor.
   logic [OP_W-1:0]    r_op;
   logic [WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]   r_opnd;
   logic [WIDTH-1:0]   r_b;
   logic [c_CNT_W-1:0] r_cnt;

   logic [WIDTH:0]     w_rem_shift;
   logic               w_sub_ok;
   logic [WIDTH-1:0]   w_diff;
   logic [WIDTH-1:0]   w_acc_nxt;
   logic [WIDTH-1:0]   w_opnd_nxt;
   logic [WIDTH-1:0]   w_b_nxt;

   assign w_rem_shift = {r_acc, r_opnd[WIDTH-1]};
   assign w_sub_ok    = (w_rem_shift >= {1'b0, r_b});
   // When the subtract succeeds the true difference is below the divisor, so it fits in WIDTH bits.
   assign w_diff      = w_rem_shift[WIDTH-1:0] - r_b;

   always_comb begin
      w_acc_nxt  = r_acc;
      w_opnd_nxt = r_opnd;
      w_b_nxt    = r_b;
      if (r_op == OP_MUL) begin
         w_acc_nxt  = r_acc + (r_b[0] ? r_opnd : '0);
         w_opnd_nxt = r_opnd << 1;
         w_b_nxt    = r_b >> 1;
      end else begin
         // A zero divisor always "subtracts", giving all-ones quotient and remainder = A.
         w_acc_nxt  = w_sub_ok ? w_diff : w_rem_shift[WIDTH-1:0];
         w_opnd_nxt = {r_opnd[WIDTH-2:0], w_sub_ok};
      end
   end

   always_comb begin
      result_o = w_acc_nxt;
      if (r_op == OP_DIVU) begin
         result_o = w_opnd_nxt;
      end
   end

   assign done_o = (r_cnt == c_CNT_W'(1));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_op   <= '0;
         r_acc  <= '0;
         r_opnd <= '0;
         r_b    <= '0;
         r_cnt  <= '0;
      end else if (start_i) begin
         r_op   <= op_i;
         r_acc  <= '0;
         r_opnd <= a_i;
         r_b    <= b_i;
         r_cnt  <= c_CNT_W'(WIDTH);
      end else if (r_cnt != '0) begin
         r_acc  <= w_acc_nxt;
         r_opnd <= w_opnd_nxt;
         r_b    <= w_b_nxt;
         r_cnt  <= r_cnt - c_CNT_W'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
// Module  : alu_seq
// Brief   : Multi-cycle ALU with valid/ready handshakes on request and result.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int OP_W  = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [OP_W-1:0]  op_i,
   input  logic [WIDTH-1:0] data1_i,
   input  logic [WIDTH-1:0] data2_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] data_o,
   output logic             zero_o,
   output logic             illegal_o,
   output logic             busy_o
);

   localparam int c_SH_W = $clog2(WIDTH);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [WIDTH-1:0]   r_data;
   logic               r_zero;
   logic               r_illegal;

   logic               w_accept;
   logic               w_iter;
   logic [c_SH_W-1:0]  w_shamt;
   logic [WIDTH-1:0]   w_res;
   logic               w_ill;
   logic               w_md_start;
   logic               w_md_done;
   logic [WIDTH-1:0]   w_md_result;

   assign w_iter     = is_iterative(op_i);
   assign w_shamt    = data2_i[c_SH_W-1:0];
   assign w_accept   = valid_i && ready_o;
   assign w_md_start = w_accept && w_iter;

   // Single-cycle datapath; iterative opcodes produce a don't-care zero here.
   always_comb begin
      w_res = '0;
      w_ill = 1'b0;
      case (op_i)
         OP_AND:  w_res = data1_i & data2_i;
         OP_OR:   w_res = data1_i | data2_i;
         OP_XOR:  w_res = data1_i ^ data2_i;
         OP_ADD:  w_res = data1_i + data2_i;
         OP_SUB:  w_res = data1_i - data2_i;
         OP_SLL:  w_res = data1_i << w_shamt;
         OP_SRL:  w_res = data1_i >> w_shamt;
         OP_SRA:  w_res = $signed(data1_i) >>> w_shamt;
         OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(data1_i) < $signed(data2_i))};
         OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (data1_i < data2_i)};
         OP_MUL, OP_DIVU, OP_REMU: w_res = '0;
         default: w_ill = 1'b1;
      endcase
   end

   alu_seq_muldiv #(
      .WIDTH (WIDTH),
      .OP_W  (OP_W)
   ) u_muldiv (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .start_i  (w_md_start),
      .op_i     (op_i),
      .a_i      (data1_i),
      .b_i      (data2_i),
      .done_o   (w_md_done),
      .result_o (w_md_result)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ready_o depends combinationally on ready_i in DONE so a result can retire
   // and a new request enter on the same edge.
   always_comb begin
      w_state_nxt = r_state;
      ready_o     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            ready_o = 1'b1;
            if (valid_i) begin
               w_state_nxt = w_iter ? ST_BUSY : ST_DONE;
            end
         end
         ST_BUSY: begin
            if (w_md_done) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (ready_i) begin
               ready_o = 1'b1;
               if (valid_i) begin
                  w_state_nxt = w_iter ? ST_BUSY : ST_DONE;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_data    <= '0;
         r_zero    <= 1'b0;
         r_illegal <= 1'b0;
      end else if (w_accept && !w_iter) begin
         r_data    <= w_res;
         r_zero    <= (w_res == '0);
         r_illegal <= w_ill;
      end else if ((r_state == ST_BUSY) && w_md_done) begin
         r_data    <= w_md_result;
         r_zero    <= (w_md_result == '0);
         r_illegal <= 1'b0;
      end
   end

   assign valid_o   = (r_state == ST_DONE);
   assign busy_o    = (r_state == ST_BUSY);
   assign data_o    = r_data;
   assign zero_o    = r_zero;
   assign illegal_o = r_illegal;

endmodule

`default_nettype wire
